// File: rtl/multiplexador_4x16_pkg.sv
// Shared definitions for the registered 4-to-1 word selector.
//   MUX_WIDTH      : default data width (16 bits)
//   SEL_A..SEL_D   : select index values formed as {sel1, sel0}
package multiplexador_4x16_pkg;

    localparam int MUX_WIDTH = 16;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_D = 2'd3;

endpackage

// File: rtl/multiplexador_4x16_mux4.sv
// Purely combinational 4-to-1 word multiplexer.
//   a, b, c, d : WIDTH-bit data channels 0..3
//   idx        : 2-bit channel index (SEL_A..SEL_D)
//   y          : selected word, bit positions preserved
module multiplexador_4x16_mux4
    import multiplexador_4x16_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       idx,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = d;
        case (idx)
            SEL_A:   y = a;
            SEL_B:   y = b;
            SEL_C:   y = c;
            SEL_D:   y = d;
            default: y = d;
        endcase
    end

endmodule

// File: rtl/multiplexador_4x16.sv
// Registered 4-to-1 selector for 16-bit words.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset (clears saida and valid)
//   A, B, C, D : data channels 0..3
//   sel0, sel1 : select bits, index = {sel1, sel0}
//   saida      : selected word, registered (one clock latency)
//   valid      : high once saida holds a post-reset selection
module multiplexador_4x16
    import multiplexador_4x16_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic             sel0,
    input  logic             sel1,
    output logic [WIDTH-1:0] saida,
    output logic             valid
);

    logic [1:0]       sel_idx;
    logic [WIDTH-1:0] mux_y;
    logic [WIDTH-1:0] saida_d;
    logic [WIDTH-1:0] saida_q;
    logic             valid_d;
    logic             valid_q;

    // Both select bits are sampled as one index on the same edge, so a
    // simultaneous change of sel0 and sel1 never registers an intermediate.
    assign sel_idx = {sel1, sel0};

    multiplexador_4x16_mux4 #(
        .WIDTH (WIDTH)
    ) u_mux4 (
        .a   (A),
        .b   (B),
        .c   (C),
        .d   (D),
        .idx (sel_idx),
        .y   (mux_y)
    );

    // No enable: the output register reloads on every edge.
    always_comb begin
        saida_d = mux_y;
        valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            saida_q <= '0;
            valid_q <= 1'b0;
        end else begin
            saida_q <= saida_d;
            valid_q <= valid_d;
        end
    end

    assign saida = saida_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_multiplexador_4x16.sv
module tb_multiplexador_4x16;

    logic        clk;
    logic        rst;
    logic [15:0] A, B, C, D;
    logic        sel0, sel1;
    logic [15:0] saida;
    logic        valid;

    int total;
    int bad;

    multiplexador_4x16 dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .sel0  (sel0),
        .sel1  (sel1),
        .saida (saida),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] a, b, c, d;
        logic [1:0]  sel;
        logic [15:0] exp_saida;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(logic r, logic [15:0] a, logic [15:0] b,
                                    logic [15:0] c, logic [15:0] d, logic [1:0] s,
                                    logic [15:0] es, logic ev);
        vec_t v;
        v.rst = r; v.a = a; v.b = b; v.c = c; v.d = d; v.sel = s;
        v.exp_saida = es; v.exp_valid = ev;
        vecs.push_back(v);
    endfunction

    // Reference: pick a channel by numeric index from an array of words.
    function automatic logic [15:0] ref_pick(logic [15:0] a, logic [15:0] b,
                                             logic [15:0] c, logic [15:0] d,
                                             int idx);
        logic [15:0] ch [4];
        ch[0] = a; ch[1] = b; ch[2] = c; ch[3] = d;
        return ch[idx];
    endfunction

    task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic r, logic [15:0] a, logic [15:0] b, logic [15:0] c,
                         logic [15:0] d, logic [1:0] s);
        rst = r; A = a; B = b; C = c; D = d;
        sel0 = s[0]; sel1 = s[1];
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b1, 16'd0, 16'd1, 16'd2, 16'd3, 2'd3);

        // Reset held two edges, then released.
        add_vec(1, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 2'd3, 16'h0000, 0);
        add_vec(1, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 2'd3, 16'h0000, 0);
        add_vec(0, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 2'd3, 16'h0003, 1);
        // Full sweep 00,01,10,11,01.
        add_vec(0, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 2'd0, 16'h0000, 1);
        add_vec(0, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 2'd1, 16'h0001, 1);
        add_vec(0, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 2'd2, 16'h0002, 1);
        add_vec(0, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 2'd3, 16'h0003, 1);
        add_vec(0, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 2'd1, 16'h0001, 1);
        // Wide patterns.
        add_vec(0, 16'hFFFF, 16'hA5A5, 16'h5A5A, 16'h8001, 2'd0, 16'hFFFF, 1);
        add_vec(0, 16'hFFFF, 16'hA5A5, 16'h5A5A, 16'h8001, 2'd1, 16'hA5A5, 1);
        add_vec(0, 16'hFFFF, 16'hA5A5, 16'h5A5A, 16'h8001, 2'd2, 16'h5A5A, 1);
        add_vec(0, 16'hFFFF, 16'hA5A5, 16'h5A5A, 16'h8001, 2'd3, 16'h8001, 1);
        // Mid-stream reset with sel=2, C=0x1234.
        add_vec(0, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 2'd2, 16'h1234, 1);
        add_vec(1, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 2'd2, 16'h0000, 0);
        add_vec(0, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 2'd2, 16'h1234, 1);
        // Data change under fixed select=1.
        add_vec(0, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 2'd1, 16'h0001, 1);
        add_vec(0, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 2'd1, 16'h00FF, 1);
        add_vec(0, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 2'd1, 16'h7FFF, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].sel);
            edge_wait();
            $display("vec %0d: rst=%b sel=%0d saida=0x%04h valid=%b", i,
                     vecs[i].rst, vecs[i].sel, saida, valid);
            chk16($sformatf("vec%0d_saida", i), saida, vecs[i].exp_saida);
            chk1($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
        end

        // Latency: mid-cycle changes are invisible until the next edge.
        drive(1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 2'd0);
        edge_wait();
        chk16("lat_base", saida, 16'h1111);
        sel0 = 1'b1;
        B    = 16'hBEEF;
        @(negedge clk);
        $display("latency mid-cycle: saida=0x%04h", saida);
        chk16("lat_hold", saida, 16'h1111);
        B = 16'hCAFE;              // last value before the edge wins
        edge_wait();
        $display("latency after edge: saida=0x%04h", saida);
        chk16("lat_new", saida, 16'hCAFE);
        // Simultaneous change of both select bits 01 -> 10.
        sel0 = 1'b0; sel1 = 1'b1;
        edge_wait();
        chk16("both_sel", saida, 16'h3333);

        // Randomized stream checked against the array-index reference.
        for (int n = 0; n < 300; n++) begin
            logic        r;
            logic [15:0] ra, rb, rc, rd;
            int          idx;
            r   = ($urandom_range(0, 15) == 0);
            ra  = 16'($urandom); rb = 16'($urandom);
            rc  = 16'($urandom); rd = 16'($urandom);
            idx = $urandom_range(0, 3);
            drive(r, ra, rb, rc, rd, 2'(idx));
            edge_wait();
            $display("rand %0d: rst=%b idx=%0d saida=0x%04h valid=%b", n, r, idx, saida, valid);
            chk16("rand_saida", saida, r ? 16'h0000 : ref_pick(ra, rb, rc, rd, idx));
            chk1("rand_valid", valid, !r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiplexador_4x16.md
# multiplexador_4x16

Registered 4-to-1 selector for 16-bit words. Picks one of four data inputs from a 2-bit select formed by two single-bit select lines and presents it on a clocked output. Sits in the datapath wherever a synchronous word-wide source selection is needed, e.g. operand or bus-source steering.

## Interface
- WIDTH, 16, data width of every data input and of `saida`
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous reset, active-high
- A  input  WIDTH  channel 0 data
- B  input  WIDTH  channel 1 data
- C  input  WIDTH  channel 2 data
- D  input  WIDTH  channel 3 data
- sel0  input  1  select bit 0 (LSB)
- sel1  input  1  select bit 1 (MSB)
- saida  output  WIDTH  registered selected word
- valid  output  1  high once `saida` holds a post-reset selection
- One clock; reset is synchronous and active-high.
- Instances connect ports by name; positional order is not guaranteed.

## Operation
- Select index is `{sel1, sel0}`: 0 selects A, 1 selects B, 2 selects C, 3 selects D.
- On every rising `clk` with `rst` low, `saida` <= selected input and `valid` <= 1.
- On rising `clk` with `rst` high, `saida` <= 0 and `valid` <= 0. Reset overrides any selection in the same cycle.
- No enable: the register reloads every cycle. A constant select with constant data holds a constant output.
- Data passes through unmodified, with no sign extension, truncation or arithmetic. All bits of the chosen input map to the same bit positions of `saida`.
- X/Z on a select bit has no defined output. The bench drives only 0/1.

## Timing
- Latency is exactly one clock: inputs sampled at edge N appear on `saida` after edge N.
- Select and data changes between edges have no effect until the next edge. There is no combinational path from inputs to outputs.
- Reset values: `saida` = 0, `valid` = 0.
- After `rst` deasserts, `valid` rises at the first edge sampled with `rst` low. That same edge loads the first selection.
- Reset asserted mid-stream clears both outputs at the next edge. Selection resumes at the first edge after deassertion.
- Simultaneous change of `sel0` and `sel1` is a single index change. No intermediate index is ever registered.

## Structure
- Shared package holds the select index constants `SEL_A`=0, `SEL_B`=1, `SEL_C`=2, `SEL_D`=3 and the default width constant 16.
- A combinational `mux4` sub-module (WIDTH-parameterized, 2-bit index) is natural. The top module wraps it with the output/valid register.

## Test plan
- Reset: hold `rst`=1 for 2 edges with A=0, B=1, C=2, D=3, sel=3 -> `saida`=0, `valid`=0. Release `rst` -> after next edge `saida`=3, `valid`=1.
- Full sweep with A=0x0000, B=0x0001, C=0x0002, D=0x0003: `{sel1,sel0}` = 00, 01, 10, 11, 01, one per edge -> `saida` = 0, 1, 2, 3, 1, each one edge after the select is applied.
- Wide patterns: A=0xFFFF, B=0xA5A5, C=0x5A5A, D=0x8001, sweep all four indices -> exact bit-for-bit match, with no bit crossing between channels.
- Latency: change `sel0` and data mid-cycle -> `saida` unchanged until the next rising edge, then the new value.
- Mid-stream reset: with sel=2 and C=0x1234 streaming, pulse `rst` for 1 edge -> `saida`=0 and `valid`=0 for that cycle, then `saida`=0x1234 and `valid`=1 on the following edge.
- Data change under fixed select: sel=1, B steps 0x0001 -> 0x00FF -> 0x7FFF on successive edges -> `saida` follows, one edge later each.
